crc_frame_serializer: RTL and testbench

- Parametrised successor to the fixed 32-bit payload / CRC-16 serializer pair.
- Accepts one payload word per valid/ready handshake and shifts it out one bit per clock, MSB- or LSB-first.
- Computes the CRC serially over the bits exactly as transmitted, then optionally appends the CRC.
- Sits between the SPI-side register/payload logic and the physical serial output; supports back-to-back frames.

---
 rtl/crc_pkg.sv | 27 ++
 rtl/crc_frame_serializer_lfsr.sv | 48 ++++
 rtl/crc_frame_serializer.sv | 143 ++++++++++++++
 tb/tb_crc_frame_serializer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and LFSR helper for the serial CRC frame path.
// crc_step works on values MSB-aligned in CRC_MAX_W bits.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CRC
    } crc_state_e;

    localparam int CRC_MAX_W = 64;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT_FFFF  = 16'hFFFF;
    localparam logic [15:0] CRC16_INIT_0000  = 16'h0000;

    function automatic logic [CRC_MAX_W-1:0] crc_step(
        input logic [CRC_MAX_W-1:0] lfsr,
        input logic                 din,
        input logic [CRC_MAX_W-1:0] poly
    );
        logic fb;
        fb = lfsr[CRC_MAX_W-1] ^ din;
        return {lfsr[CRC_MAX_W-2:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/crc_frame_serializer_lfsr.sv
// Bit-serial CRC LFSR: load, feed payload bits, or shift out plain.
// Load has priority so a new frame can start on the last bit.
module crc_lfsr_serial
    import crc_pkg::*;
#(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC16_CCITT_POLY,
    parameter logic [CRC_W-1:0] INIT  = CRC16_INIT_FFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_in_en_i,
    input  logic             shift_out_en_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] lfsr_o
);

    localparam int PAD = CRC_MAX_W - CRC_W;

    logic [CRC_W-1:0]     lfsr_q;
    logic [CRC_W-1:0]     lfsr_d;
    logic [CRC_MAX_W-1:0] step_w;

    always_comb begin
        step_w = crc_step(CRC_MAX_W'(lfsr_q) << PAD, bit_i,
                          CRC_MAX_W'(POLY) << PAD);
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = INIT;
        end else if (shift_in_en_i) begin
            lfsr_d = CRC_W'(step_w >> PAD);
        end else if (shift_out_en_i) begin
            lfsr_d = {lfsr_q[CRC_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= INIT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/crc_frame_serializer.sv
// Payload word to serial bit stream with optional appended CRC.
// Supports back-to-back frames by accepting during the last bit.
module crc_frame_serializer
    import crc_pkg::*;
#(
    parameter int               DATA_W   = 32,
    parameter int               CRC_W    = 16,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC16_CCITT_POLY,
    parameter logic [CRC_W-1:0] CRC_INIT = CRC16_INIT_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_lsb_first,
    input  logic              in_crc_en,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              done_tick,
    output logic              busy,
    output logic [CRC_W-1:0]  crc_value
);

    localparam int CNT_MAX = (DATA_W > CRC_W) ? DATA_W : CRC_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PAD     = CRC_MAX_W - CRC_W;

    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_W - 1);

    crc_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              lsb_q, lsb_d;
    logic              crc_en_q, crc_en_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CRC_W-1:0]  fcrc_q, fcrc_d;
    logic [CRC_W-1:0]  crc_value_q, crc_value_d;
    logic              done_q;

    logic [CRC_W-1:0]  lfsr;
    logic [CRC_W-1:0]  crc_after;
    logic              pay_bit;
    logic              pay_last;
    logic              crc_last;
    logic              accept;

    assign pay_bit  = lsb_q ? shreg_q[0] : shreg_q[DATA_W-1];
    assign pay_last = (state_q == PAYLOAD) && (cnt_q == PAY_LAST);
    assign crc_last = (state_q == CRC) && (cnt_q == CRC_LAST);

    // LFSR value once the current payload bit is folded in
    assign crc_after = CRC_W'(crc_step(CRC_MAX_W'(lfsr) << PAD, pay_bit,
                                       CRC_MAX_W'(CRC_POLY) << PAD) >> PAD);

    assign ser_valid = (state_q != IDLE);
    assign ser_out   = (state_q == PAYLOAD) ? pay_bit :
                       (state_q == CRC)     ? lfsr[CRC_W-1] : 1'b0;
    assign ser_last  = (pay_last && !crc_en_q) || crc_last;
    assign in_ready  = (state_q == IDLE) || ser_last;
    assign accept    = in_valid && in_ready;
    assign busy      = ser_valid;
    assign done_tick = done_q;
    assign crc_value = crc_value_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        lsb_d       = lsb_q;
        crc_en_d    = crc_en_q;
        cnt_d       = cnt_q + 1'b1;
        fcrc_d      = fcrc_q;
        crc_value_d = crc_value_q;
        unique case (state_q)
            PAYLOAD: begin
                shreg_d = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
                if (pay_last) begin
                    cnt_d   = '0;
                    fcrc_d  = crc_after;
                    state_d = crc_en_q ? CRC : IDLE;
                    if (!crc_en_q) begin
                        crc_value_d = crc_after;
                    end
                end
            end
            CRC: begin
                if (crc_last) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    crc_value_d = fcrc_q;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        if (accept) begin
            state_d  = PAYLOAD;
            cnt_d    = '0;
            shreg_d  = in_data;
            lsb_d    = in_lsb_first;
            crc_en_d = in_crc_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            lsb_q       <= 1'b0;
            crc_en_q    <= 1'b0;
            cnt_q       <= '0;
            fcrc_q      <= '0;
            crc_value_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            lsb_q       <= lsb_d;
            crc_en_q    <= crc_en_d;
            cnt_q       <= cnt_d;
            fcrc_q      <= fcrc_d;
            crc_value_q <= crc_value_d;
            done_q      <= ser_last;
        end
    end

    crc_lfsr_serial #(
        .CRC_W (CRC_W),
        .POLY  (CRC_POLY),
        .INIT  (CRC_INIT)
    ) u_lfsr (
        .clk            (clk),
        .reset          (reset),
        .load_i         (accept),
        .shift_in_en_i  (state_q == PAYLOAD),
        .shift_out_en_i (state_q == CRC),
        .bit_i          (pay_bit),
        .lfsr_o         (lfsr)
    );

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Directed bench for crc_frame_serializer over four configurations.
// Instances: 72b/init0, 72b/initFFFF, 8b/init0, 32b/initFFFF.
module tb_crc_frame_serializer;

    logic        clk;
    logic        reset;
    logic [71:0] din;
    logic        iv   [4];
    logic        lsbv [4];
    logic        cev  [4];
    logic        rdy  [4];
    logic        so   [4];
    logic        sv   [4];
    logic        sl   [4];
    logic        dt   [4];
    logic        bz   [4];
    logic [15:0] cv   [4];

    int total;
    int passed;

    typedef struct {
        int          inst;
        int          w;
        logic [71:0] data;
        logic        lsb;
        logic        ce;
        logic [15:0] crc;
        int          poke;
    } vec_t;

    vec_t vt [8];

    localparam logic [71:0] STR9 = 72'h313233343536373839;

    crc_frame_serializer #(.DATA_W(72), .CRC_W(16),
        .CRC_POLY(16'h1021), .CRC_INIT(16'h0000)) u0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy[0]),
        .in_data(din), .in_lsb_first(lsbv[0]), .in_crc_en(cev[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .ser_last(sl[0]),
        .done_tick(dt[0]), .busy(bz[0]), .crc_value(cv[0]));

    crc_frame_serializer #(.DATA_W(72), .CRC_W(16),
        .CRC_POLY(16'h1021), .CRC_INIT(16'hFFFF)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy[1]),
        .in_data(din), .in_lsb_first(lsbv[1]), .in_crc_en(cev[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .ser_last(sl[1]),
        .done_tick(dt[1]), .busy(bz[1]), .crc_value(cv[1]));

    crc_frame_serializer #(.DATA_W(8), .CRC_W(16),
        .CRC_POLY(16'h1021), .CRC_INIT(16'h0000)) u2 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(rdy[2]),
        .in_data(din[7:0]), .in_lsb_first(lsbv[2]), .in_crc_en(cev[2]),
        .ser_out(so[2]), .ser_valid(sv[2]), .ser_last(sl[2]),
        .done_tick(dt[2]), .busy(bz[2]), .crc_value(cv[2]));

    crc_frame_serializer #(.DATA_W(32), .CRC_W(16),
        .CRC_POLY(16'h1021), .CRC_INIT(16'hFFFF)) u3 (
        .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(rdy[3]),
        .in_data(din[31:0]), .in_lsb_first(lsbv[3]), .in_crc_en(cev[3]),
        .ser_out(so[3]), .ser_valid(sv[3]), .ser_last(sl[3]),
        .done_tick(dt[3]), .busy(bz[3]), .crc_value(cv[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Plain bitwise CRC-16/1021 used for the 32-bit frames
    function automatic logic [15:0] crc_ref(input logic [71:0] d, input int w,
                                            input logic lsb, input logic [15:0] init);
        logic [15:0] c;
        logic        b;
        c = init;
        for (int i = 0; i < w; i++) begin
            b = lsb ? d[i] : d[w-1-i];
            c = (c[15] ^ b) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic run_frame(input int id, input vec_t v);
        logic [87:0] got, exp;
        int n, lastpos, dones, dpos, len, k;
        bit gap, bok;
        k = v.inst;
        len = v.w + (v.ce ? 16 : 0);
        got = '0; exp = '0;
        n = 0; lastpos = -1; dones = 0; dpos = -1; gap = 0; bok = 1;
        for (int i = 0; i < v.w; i++) exp[i] = v.lsb ? v.data[i] : v.data[v.w-1-i];
        if (v.ce) for (int j = 0; j < 16; j++) exp[v.w+j] = v.crc[15-j];
        @(negedge clk);
        chk($sformatf("v%0d_ready_idle", id), rdy[k], 1'b1);
        din = v.data; lsbv[k] = v.lsb; cev[k] = v.ce; iv[k] = 1'b1;
        @(negedge clk);
        iv[k] = 1'b0; din = ~v.data; lsbv[k] = ~v.lsb; cev[k] = ~v.ce;
        for (int c = 0; c < len + 4; c++) begin
            if (sv[k]) begin
                if (n != c) gap = 1;
                got[n] = so[k];
                if (sl[k]) lastpos = n;
                if (!bz[k]) bok = 0;
                n++;
            end
            if (dt[k]) begin
                if (dpos < 0) dpos = c;
                dones++;
            end
            iv[k] = (c == v.poke);
            @(negedge clk);
        end
        iv[k] = 1'b0;
        chk($sformatf("v%0d_valid_cycles", id), n, len);
        chk($sformatf("v%0d_contiguous", id), gap, 1'b0);
        chk($sformatf("v%0d_last_pos", id), lastpos, len - 1);
        chk($sformatf("v%0d_done_count", id), dones, 1);
        chk($sformatf("v%0d_done_pos", id), dpos, len);
        chk($sformatf("v%0d_stream", id), got, exp);
        chk($sformatf("v%0d_crc_value", id), cv[k], v.crc);
        chk($sformatf("v%0d_busy_in_frame", id), bok, 1'b1);
        chk($sformatf("v%0d_busy_end", id), bz[k], 1'b0);
        chk($sformatf("v%0d_ready_end", id), rdy[k], 1'b1);
        chk($sformatf("v%0d_valid_end", id), sv[k], 1'b0);
    endtask

    task automatic back_to_back();
        logic [31:0] w1, w2;
        logic [87:0] got, exp;
        int n, lasts, dones;
        int lp [2];
        int dp [2];
        bit gap, bok, pend;
        w1 = 32'hA5A50F0F; w2 = 32'h12345678;
        got = '0; exp = '0; n = 0; lasts = 0; dones = 0;
        lp = '{-1, -1}; dp = '{-1, -1}; gap = 0; bok = 1; pend = 0;
        for (int i = 0; i < 32; i++) begin
            exp[i] = w1[31-i];
            exp[32+i] = w2[i];
        end
        @(negedge clk);
        din = 72'(w1); lsbv[3] = 1'b0; cev[3] = 1'b0; iv[3] = 1'b1;
        @(negedge clk);
        din = 72'(w2); lsbv[3] = 1'b1;
        for (int c = 0; c < 72; c++) begin
            if (sv[3]) begin
                if (n != c) gap = 1;
                got[n] = so[3];
                if (!bz[3]) bok = 0;
                if (sl[3]) begin
                    if (lasts < 2) lp[lasts] = n;
                    lasts++;
                end
                n++;
            end
            if (dt[3]) begin
                if (dones < 2) dp[dones] = c;
                dones++;
            end
            if (pend) begin
                iv[3] = 1'b0;
                din = '1;
            end
            pend = sl[3] && (lasts == 1);
            @(negedge clk);
        end
        iv[3] = 1'b0;
        chk("b2b_valid_cycles", n, 64);
        chk("b2b_contiguous", gap, 1'b0);
        chk("b2b_last1_pos", lp[0], 31);
        chk("b2b_last2_pos", lp[1], 63);
        chk("b2b_last_count", lasts, 2);
        chk("b2b_done_count", dones, 2);
        chk("b2b_done1_pos", dp[0], 32);
        chk("b2b_done2_pos", dp[1], 64);
        chk("b2b_stream", got, exp);
        chk("b2b_crc_value", cv[3], crc_ref(72'(w2), 32, 1'b1, 16'hFFFF));
        chk("b2b_busy_in_frame", bok, 1'b1);
        chk("b2b_busy_end", bz[3], 1'b0);
    endtask

    task automatic reset_mid_frame();
        @(negedge clk);
        din = 72'h0BADF00D; lsbv[3] = 1'b0; cev[3] = 1'b1; iv[3] = 1'b1;
        @(negedge clk);
        iv[3] = 1'b0;
        repeat (10) @(negedge clk);
        chk("rstmid_pre_valid", sv[3], 1'b1);
        chk("rstmid_pre_busy", bz[3], 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", sv[3], 1'b0);
        chk("rstmid_busy", bz[3], 1'b0);
        chk("rstmid_ready", rdy[3], 1'b1);
        chk("rstmid_crc_value", cv[3], 16'h0000);
        chk("rstmid_ser_out", so[3], 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_no_done", dt[3], 1'b0);
    endtask

    initial begin
        vec_t fresh;
        total = 0; passed = 0;
        reset = 1'b1; din = '0;
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b0; lsbv[k] = 1'b0; cev[k] = 1'b0;
        end

        vt[0] = '{inst:0, w:72, data:STR9, lsb:1'b0, ce:1'b0, crc:16'h31C3, poke:-1};
        vt[1] = '{inst:0, w:72, data:STR9, lsb:1'b0, ce:1'b1, crc:16'h31C3, poke:-1};
        vt[2] = '{inst:1, w:72, data:STR9, lsb:1'b0, ce:1'b1, crc:16'h29B1, poke:-1};
        vt[3] = '{inst:2, w:8, data:72'h80, lsb:1'b0, ce:1'b1, crc:16'h9188, poke:-1};
        vt[4] = '{inst:2, w:8, data:72'h80, lsb:1'b1, ce:1'b1, crc:16'h1021, poke:-1};
        vt[5] = '{inst:3, w:32, data:72'hDEADBEEF, lsb:1'b1, ce:1'b1,
                  crc:crc_ref(72'hDEADBEEF, 32, 1'b1, 16'hFFFF), poke:-1};
        vt[6] = '{inst:3, w:32, data:72'h00000001, lsb:1'b0, ce:1'b0,
                  crc:crc_ref(72'h00000001, 32, 1'b0, 16'hFFFF), poke:-1};
        vt[7] = '{inst:3, w:32, data:72'hCAFEF00D, lsb:1'b0, ce:1'b1,
                  crc:crc_ref(72'hCAFEF00D, 32, 1'b0, 16'hFFFF), poke:5};

        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst%0d_ser_valid", k), sv[k], 1'b0);
            chk($sformatf("rst%0d_ser_out", k), so[k], 1'b0);
            chk($sformatf("rst%0d_ser_last", k), sl[k], 1'b0);
            chk($sformatf("rst%0d_done", k), dt[k], 1'b0);
            chk($sformatf("rst%0d_busy", k), bz[k], 1'b0);
            chk($sformatf("rst%0d_crc_value", k), cv[k], 16'h0000);
            chk($sformatf("rst%0d_ready", k), rdy[k], 1'b1);
        end
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_frame(i, vt[i]);

        back_to_back();
        reset_mid_frame();

        fresh = '{inst:3, w:32, data:72'h0BADF00D, lsb:1'b0, ce:1'b1,
                  crc:crc_ref(72'h0BADF00D, 32, 1'b0, 16'hFFFF), poke:-1};
        run_frame(8, fresh);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
